// File: rtl/nexys_starship_pkg.sv
// -----------------------------------------------------------------------------
// nexys_starship_pkg
// Shared constants for the starship spawn scheduler:
//   - one-hot FSM state encoding (IDLE / RUN / OVER)
//   - LFSR seed and feedback taps (x^8 + x^6 + x^5 + x^4 + 1)
//   - counter widths for the game timer and per-monster age
// No ports; imported by the interface, the LFSR and the scheduler top.
// -----------------------------------------------------------------------------
package nexys_starship_pkg;

    localparam logic [2:0] ST_IDLE = 3'b001;
    localparam logic [2:0] ST_RUN  = 3'b010;
    localparam logic [2:0] ST_OVER = 3'b100;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Tap mask for a left-shifting Fibonacci LFSR: bits 7, 5, 4, 3.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam int TIMER_W = 16;
    localparam int AGE_W   = 4;

    function automatic logic [7:0] lfsr_step(input logic [7:0] q);
        return {q[6:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/nexys_starship_spawn_scheduler_if.sv
// -----------------------------------------------------------------------------
// nexys_starship_spawn_scheduler_if
// Bundles the scheduler's game-side signals.
//   play            game FSM -> scheduler, level, high while in PLAY
//   kill            terminals -> scheduler, per-terminal one-cycle pulses
//   monster_active  scheduler -> terminals/VGA, bit i = live monster at i
//   spawn_pulse     scheduler -> game, one-cycle pulse per successful spawn
//   game_over_req   scheduler -> game FSM, level, timeout until play drops
//   game_timer      scheduler -> display, elapsed ticks (saturating)
//   spawn_interval  scheduler -> display, ticks between spawns
// master = game/terminal side, slave = scheduler.
// -----------------------------------------------------------------------------
interface nexys_starship_spawn_scheduler_if #(
    parameter int NUM_TERM = 4
);
    logic                                   play;
    logic [NUM_TERM-1:0]                    kill;
    logic [NUM_TERM-1:0]                    monster_active;
    logic                                   spawn_pulse;
    logic                                   game_over_req;
    logic [nexys_starship_pkg::TIMER_W-1:0] game_timer;
    logic [3:0]                             spawn_interval;

    modport master (
        output play, kill,
        input  monster_active, spawn_pulse, game_over_req, game_timer, spawn_interval
    );

    modport slave (
        input  play, kill,
        output monster_active, spawn_pulse, game_over_req, game_timer, spawn_interval
    );
endinterface

// File: rtl/nexys_starship_lfsr8.sv
// -----------------------------------------------------------------------------
// nexys_starship_lfsr8
// Free-running 8-bit Fibonacci LFSR (x^8 + x^6 + x^5 + x^4 + 1) used to pick
// spawn terminals. Steps every clock in every game state; the non-zero seed
// guarantees the register never reaches the all-zero lock-up state.
//   Clk    in   system clock
//   Reset  in   synchronous, active-high; loads the seed
//   q      out  current LFSR value
// -----------------------------------------------------------------------------
module nexys_starship_lfsr8
    import nexys_starship_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    output logic [7:0] q
);
    logic [7:0] r_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_q <= LFSR_SEED;
        end else begin
            r_q <= lfsr_step(r_q);
        end
    end

    assign q = r_q;
endmodule

// File: rtl/nexys_starship_spawn_scheduler.sv
// -----------------------------------------------------------------------------
// nexys_starship_spawn_scheduler
// Spawns monsters onto the ship's terminals while the game is in PLAY, keeps
// the game-time counter, shortens the spawn interval as the game progresses,
// ages each live monster and requests game over when one outlives TIMEOUT.
//   Clk    in   system clock
//   Reset  in   synchronous, active-high reset
//   bus    slave modport: play/kill in; monster_active, spawn_pulse,
//          game_over_req, game_timer, spawn_interval out
// Within one RUN cycle the order is: kills, then timeout check, then spawn.
// -----------------------------------------------------------------------------
module nexys_starship_spawn_scheduler
    import nexys_starship_pkg::*;
#(
    parameter int NUM_TERM    = 4,
    parameter int TICK_DIV    = 50_000_000,
    parameter int SPAWN_START = 8,
    parameter int SPAWN_MIN   = 2,
    parameter int RAMP_EVERY  = 4,
    parameter int TIMEOUT     = 5
) (
    input  logic Clk,
    input  logic Reset,
    nexys_starship_spawn_scheduler_if.slave bus
);
    localparam int IDX_W   = $clog2(NUM_TERM);
    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [2:0]          r_state;
    logic [NUM_TERM-1:0] r_active;
    logic [AGE_W-1:0]    r_age [NUM_TERM];
    logic [PRESC_W-1:0]  r_presc;
    logic [TIMER_W-1:0]  r_timer;
    logic [3:0]          r_interval;
    logic [3:0]          r_spawn_cnt;
    logic [3:0]          r_ramp_cnt;
    logic                r_ramp_pend;
    logic                r_spawn_pulse;
    logic                r_game_over;

    logic [7:0]          w_lfsr;
    logic                w_lfsr_unused;
    logic                w_tick;
    logic [NUM_TERM-1:0] w_kill_hit;
    logic [NUM_TERM-1:0] w_live;
    logic                w_timeout;
    logic                w_spawn_due;
    logic [IDX_W-1:0]    w_cand;
    logic [IDX_W-1:0]    w_probe;
    logic [IDX_W-1:0]    w_spawn_idx;
    logic                w_found;
    logic                w_do_spawn;
    logic [NUM_TERM-1:0] w_spawn_mask;
    logic [3:0]          w_next_interval;

    nexys_starship_lfsr8 u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .q     (w_lfsr)
    );

    assign w_cand        = w_lfsr[IDX_W-1:0];
    assign w_lfsr_unused = ^w_lfsr[7:IDX_W];

    assign w_tick      = (r_state == ST_RUN) && (r_presc == PRESC_W'(TICK_DIV - 1));
    assign w_kill_hit  = r_active & bus.kill;
    // Survivors after this cycle's kills; kills on idle terminals fall out here.
    assign w_live      = r_active & ~bus.kill;
    assign w_spawn_due = w_tick && (r_spawn_cnt <= 4'd1);
    assign w_do_spawn  = w_spawn_due && w_found && !w_timeout;

    // A pending ramp step lands on the reload that starts the next countdown,
    // so spawn_interval always shows the interval currently being counted.
    assign w_next_interval = (r_ramp_pend && (r_interval > 4'(SPAWN_MIN)))
                           ? r_interval - 4'd1 : r_interval;

    // Timeout only counts monsters that survive this cycle's kills.
    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_timeout = 1'b0;
        for (int i = 0; i < NUM_TERM; i++) begin
            if (w_tick && w_live[i] && (r_age[i] == AGE_W'(TIMEOUT - 1))) begin
                w_timeout = 1'b1;
            end
        end
    end

    // First free terminal at or after the LFSR candidate, wrapping modulo
    // NUM_TERM (a power of two, so IDX_W-bit addition wraps for free).
    always_comb begin
        w_found      = 1'b0;
        w_spawn_idx  = '0;
        w_probe      = '0;
        w_spawn_mask = '0;
        for (int k = 0; k < NUM_TERM; k++) begin
            w_probe = w_cand + IDX_W'(k);
            if (!w_found && !w_live[w_probe]) begin
                w_found     = 1'b1;
                w_spawn_idx = w_probe;
            end
        end
        if (w_do_spawn) begin
            w_spawn_mask[w_spawn_idx] = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state       <= ST_IDLE;
            r_active      <= '0;
            r_presc       <= '0;
            r_timer       <= '0;
            r_interval    <= 4'(SPAWN_START);
            r_spawn_cnt   <= '0;
            r_ramp_cnt    <= '0;
            r_ramp_pend   <= 1'b0;
            r_spawn_pulse <= 1'b0;
            r_game_over   <= 1'b0;
            // NOTE: the age array is a handful of flops, not RAM, so it is
            // reset explicitly like any other register.
            for (int i = 0; i < NUM_TERM; i++) begin
                r_age[i] <= '0;
            end
        end else begin
            r_spawn_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.play) begin
                        r_state     <= ST_RUN;
                        r_active    <= '0;
                        r_presc     <= '0;
                        r_timer     <= '0;
                        r_interval  <= 4'(SPAWN_START);
                        r_spawn_cnt <= 4'(SPAWN_START);
                        r_ramp_cnt  <= '0;
                        r_ramp_pend <= 1'b0;
                        for (int i = 0; i < NUM_TERM; i++) begin
                            r_age[i] <= '0;
                        end
                    end
                end

                ST_RUN: begin
                    if (!bus.play) begin
                        r_state  <= ST_IDLE;
                        r_active <= '0;
                    end else begin
                        r_active <= w_live | w_spawn_mask;
                        r_presc  <= w_tick ? '0 : r_presc + PRESC_W'(1);

                        for (int i = 0; i < NUM_TERM; i++) begin
                            if (w_kill_hit[i]) begin
                                r_age[i] <= '0;
                            end else if (w_tick && w_live[i]) begin
                                r_age[i] <= r_age[i] + AGE_W'(1);
                            end
                        end

                        if (w_tick) begin
                            if (r_timer != '1) begin
                                r_timer <= r_timer + TIMER_W'(1);
                            end
                            if (w_spawn_due) begin
                                r_spawn_cnt <= w_next_interval;
                                r_interval  <= w_next_interval;
                                r_ramp_pend <= 1'b0;
                            end else begin
                                r_spawn_cnt <= r_spawn_cnt - 4'd1;
                            end
                            if (w_timeout) begin
                                r_state     <= ST_OVER;
                                r_game_over <= 1'b1;
                            end
                        end

                        // Later assignments override the age increment and the
                        // pending-ramp clear above for the spawned terminal.
                        if (w_do_spawn) begin
                            r_age[w_spawn_idx] <= '0;
                            r_spawn_pulse      <= 1'b1;
                            if (r_ramp_cnt == 4'(RAMP_EVERY - 1)) begin
                                r_ramp_cnt  <= '0;
                                r_ramp_pend <= 1'b1;
                            end else begin
                                r_ramp_cnt <= r_ramp_cnt + 4'd1;
                            end
                        end
                    end
                end

                ST_OVER: begin
                    // Counters and monsters stay frozen for the end screen.
                    if (!bus.play) begin
                        r_state     <= ST_IDLE;
                        r_active    <= '0;
                        r_game_over <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.monster_active = r_active;
    assign bus.spawn_pulse    = r_spawn_pulse;
    assign bus.game_over_req  = r_game_over;
    assign bus.game_timer     = r_timer;
    assign bus.spawn_interval = r_interval;
endmodule

// File: tb/tb_nexys_starship_spawn_scheduler.sv
// -----------------------------------------------------------------------------
// tb_nexys_starship_spawn_scheduler
// Directed bench with two scheduler instances sharing Clk/Reset:
//   dut_a: TICK_DIV=4, SPAWN_START=3, SPAWN_MIN=1, RAMP_EVERY=2, TIMEOUT=5
//   dut_b: same but TIMEOUT=15, used to fill every terminal
// A tick lands every 4 cycles; with RUN entered at edge E1 the tick for game
// time t is processed at edge E(1+4t).
// -----------------------------------------------------------------------------
module tb_nexys_starship_spawn_scheduler;
    import nexys_starship_pkg::*;

    localparam int NT = 4;

    logic Clk;
    logic Reset;
    int   total;
    int   bad;

    // Expected game time and interval right after each spawn of the kill game.
    int exp_t [8] = '{3, 6, 9, 11, 13, 14, 15, 16};
    int exp_i [8] = '{3, 3, 2, 2, 1, 1, 1, 1};

    nexys_starship_spawn_scheduler_if #(.NUM_TERM(NT)) if_a ();
    nexys_starship_spawn_scheduler_if #(.NUM_TERM(NT)) if_b ();

    nexys_starship_spawn_scheduler #(
        .NUM_TERM(NT), .TICK_DIV(4), .SPAWN_START(3), .SPAWN_MIN(1),
        .RAMP_EVERY(2), .TIMEOUT(5)
    ) dut_a (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (if_a)
    );

    nexys_starship_spawn_scheduler #(
        .NUM_TERM(NT), .TICK_DIV(4), .SPAWN_START(3), .SPAWN_MIN(1),
        .RAMP_EVERY(2), .TIMEOUT(15)
    ) dut_b (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (if_b)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic start_a();
        if_a.play = 1'b1;
        step(1);
        check("a_enter_run", 32'(dut_a.r_state), 32'(ST_RUN));
    endtask

    initial begin
        int n;
        int pulses;
        total = 0;
        bad   = 0;
        Reset = 1'b1;
        if_a.play = 1'b0;
        if_a.kill = '0;
        if_b.play = 1'b0;
        if_b.kill = '0;
        step(3);
        Reset = 1'b0;
        step(1);

        // ---- reset state ----
        check("rst_active",   32'(if_a.monster_active), 32'h0);
        check("rst_pulse",    32'(if_a.spawn_pulse),    32'h0);
        check("rst_gameover", 32'(if_a.game_over_req),  32'h0);
        check("rst_timer",    32'(if_a.game_timer),     32'h0);
        check("rst_interval", 32'(if_a.spawn_interval), 32'd3);
        check("rst_state",    32'(dut_a.r_state),       32'(ST_IDLE));
        check("rst_b_interval", 32'(if_b.spawn_interval), 32'd3);

        // ---- game 1: first spawn latency, then leave monster 1 to time out ----
        start_a();                                   // E1
        step(11);                                    // E12
        check("g1_pre_pulse",  32'(if_a.spawn_pulse), 32'h0);
        check("g1_pre_timer",  32'(if_a.game_timer),  32'd2);
        check("g1_pre_active", 32'(if_a.monster_active), 32'h0);
        step(1);                                     // E13: tick 3 spawn
        check("g1_spawn1_pulse", 32'(if_a.spawn_pulse), 32'h1);
        check("g1_spawn1_count", 32'($countones(if_a.monster_active)), 32'd1);
        check("g1_spawn1_timer", 32'(if_a.game_timer), 32'd3);
        step(1);                                     // E14
        check("g1_pulse_width", 32'(if_a.spawn_pulse), 32'h0);
        step(11);                                    // E25: tick 6 spawn
        check("g1_spawn2_pulse", 32'(if_a.spawn_pulse), 32'h1);
        check("g1_spawn2_count", 32'($countones(if_a.monster_active)), 32'd2);
        check("g1_spawn2_interval", 32'(if_a.spawn_interval), 32'd3);
        step(7);                                     // E32
        check("g1_pre_over_gor",   32'(if_a.game_over_req), 32'h0);
        check("g1_pre_over_timer", 32'(if_a.game_timer),    32'd7);
        step(1);                                     // E33: tick 8, age hits 5
        check("g1_over_gor",   32'(if_a.game_over_req), 32'h1);
        check("g1_over_state", 32'(dut_a.r_state),      32'(ST_OVER));
        check("g1_over_timer", 32'(if_a.game_timer),    32'd8);
        check("g1_over_count", 32'($countones(if_a.monster_active)), 32'd2);
        step(5);
        check("g1_frozen_timer", 32'(if_a.game_timer),    32'd8);
        check("g1_frozen_gor",   32'(if_a.game_over_req), 32'h1);
        check("g1_frozen_count", 32'($countones(if_a.monster_active)), 32'd2);
        if_a.play = 1'b0;
        step(1);
        check("g1_end_active", 32'(if_a.monster_active), 32'h0);
        check("g1_end_gor",    32'(if_a.game_over_req),  32'h0);
        check("g1_end_state",  32'(dut_a.r_state),       32'(ST_IDLE));

        // ---- game 2: reset mid-RUN with two live monsters ----
        start_a();                                   // F1
        step(24);                                    // F25
        check("g2_two_live", 32'($countones(if_a.monster_active)), 32'd2);
        check("g2_timer",    32'(if_a.game_timer), 32'd6);
        step(2);
        Reset     = 1'b1;
        if_a.play = 1'b0;
        step(1);
        Reset = 1'b0;
        check("g2_rst_active",   32'(if_a.monster_active), 32'h0);
        check("g2_rst_pulse",    32'(if_a.spawn_pulse),    32'h0);
        check("g2_rst_gor",      32'(if_a.game_over_req),  32'h0);
        check("g2_rst_timer",    32'(if_a.game_timer),     32'h0);
        check("g2_rst_interval", 32'(if_a.spawn_interval), 32'd3);
        check("g2_rst_state",    32'(dut_a.r_state),       32'(ST_IDLE));
        step(1);

        // ---- game 3: kill every spawn at once, watch the interval ramp ----
        start_a();                                   // G1
        for (int s = 0; s < 8; s++) begin
            n = 0;
            while (!if_a.spawn_pulse && n < 20) begin
                step(1);
                n++;
            end
            check($sformatf("g3_spawn_seen_%0d", s + 1), 32'(if_a.spawn_pulse), 32'h1);
            check($sformatf("g3_timer_%0d", s + 1),    32'(if_a.game_timer), 32'(exp_t[s]));
            check($sformatf("g3_interval_%0d", s + 1), 32'(if_a.spawn_interval), 32'(exp_i[s]));
            check($sformatf("g3_one_bit_%0d", s + 1),
                  32'($countones(if_a.monster_active)), 32'd1);
            if_a.kill = 4'hF;
            step(1);
            if_a.kill = '0;
            check($sformatf("g3_killed_%0d", s + 1), 32'(if_a.monster_active), 32'h0);
        end
        check("g3_no_gameover", 32'(if_a.game_over_req), 32'h0);
        if_a.play = 1'b0;
        step(1);
        check("g3_end_state", 32'(dut_a.r_state), 32'(ST_IDLE));

        // ---- game 4: kill lands on the timeout tick ----
        start_a();                                   // H1
        step(31);                                    // H32
        check("g4_pre_count", 32'($countones(if_a.monster_active)), 32'd2);
        if_a.kill = 4'hF;
        step(1);                                     // H33: tick 8
        if_a.kill = '0;
        check("g4_saved_gor",    32'(if_a.game_over_req),  32'h0);
        check("g4_saved_active", 32'(if_a.monster_active), 32'h0);
        check("g4_saved_timer",  32'(if_a.game_timer),     32'd8);
        step(1);
        check("g4_still_run", 32'(dut_a.r_state),      32'(ST_RUN));
        check("g4_still_gor", 32'(if_a.game_over_req), 32'h0);
        step(3);                                     // H37: tick 9 spawn
        check("g4_next_spawn", 32'(if_a.spawn_pulse), 32'h1);
        check("g4_next_count", 32'($countones(if_a.monster_active)), 32'd1);
        if_a.play = 1'b0;
        step(1);
        check("g4_end_state", 32'(dut_a.r_state), 32'(ST_IDLE));

        // ---- game 5 on dut_b: fill every terminal, later slots give nothing ----
        if_b.play = 1'b1;
        step(1);                                     // B1
        pulses = 0;
        for (int c = 0; c < 56; c++) begin           // through B57 (tick 14)
            step(1);
            if (if_b.spawn_pulse) pulses++;
        end
        check("g5_pulse_count", 32'(pulses), 32'd4);
        check("g5_all_full",    32'(if_b.monster_active), 32'hF);
        check("g5_timer",       32'(if_b.game_timer), 32'd14);
        check("g5_no_gameover", 32'(if_b.game_over_req), 32'h0);
        if_b.play = 1'b0;
        step(1);
        check("g5_end_active", 32'(if_b.monster_active), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
